// File: rtl/tx_slice_arbiter.sv
// Round-robin TX launch arbiter fed by the four-slice time-slice generator.
// Grants one queue at a time and holds it until tx_done or a microsecond timeout.
module tx_slice_arbiter #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tsf_pulse_1M,
  input  logic                 slice_en0,
  input  logic                 slice_en1,
  input  logic                 slice_en2,
  input  logic                 slice_en3,
  input  logic [3:0]           queue_nonempty,
  input  logic [3:0]           queue_disable,
  input  logic                 tx_idle,
  input  logic                 tx_done,
  input  logic [TIMEOUT_W-1:0] timeout_us,
  output logic                 tx_start,
  output logic [1:0]           tx_queue_idx,
  output logic                 tx_busy,
  output logic                 tx_timeout,
  output logic                 slice_overrun
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [1:0]           last_idx_q, last_idx_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 start_q, start_d;
  logic [1:0]           idx_q, idx_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic                 overrun_q, overrun_d;

  logic [3:0] slice_en;
  logic [3:0] elig;
  logic       sel_found;
  logic [1:0] sel_idx;
  logic [1:0] cand;

  assign slice_en = {slice_en3, slice_en2, slice_en1, slice_en0};
  assign elig     = slice_en & queue_nonempty & ~queue_disable & {4{tx_idle}};

  // Search starts just after the last-served queue, so it ends up with lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last_idx_q;
    cand      = last_idx_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_idx_q + 2'(k);
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    idx_d      = idx_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          idx_d   = sel_idx;
          start_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tsf_pulse_1M && (cnt_q != '1)) begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
        // Done takes precedence over a timeout hitting in the same cycle.
        if (tx_done) begin
          state_d    = ST_IDLE;
          last_idx_d = idx_q;
          busy_d     = 1'b0;
          overrun_d  = ~slice_en[idx_q];
        end else if ((timeout_us != '0) && (cnt_q == timeout_us)) begin
          state_d    = ST_IDLE;
          last_idx_d = idx_q;
          busy_d     = 1'b0;
          timeout_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_idx_q <= 2'd3;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      idx_q      <= 2'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign tx_start      = start_q;
  assign tx_queue_idx  = idx_q;
  assign tx_busy       = busy_q;
  assign tx_timeout    = timeout_q;
  assign slice_overrun = overrun_q;

endmodule
